sliding_window_accumulator: RTL

SLIDING_WINDOW_ACCUMULATOR -- requirements
Module: sliding_window_accumulator

---
 rtl/sliding_window_accumulator_pkg.sv | 17 +
 rtl/window_fill_ctrl.sv | 64 ++++++
 rtl/sliding_window_accumulator.sv | 74 +++++++
 3 files changed

// File: rtl/sliding_window_accumulator_pkg.sv
// Shared window-state encoding and the accumulator width rule
// for the sliding window accumulator.
package sliding_window_accumulator_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_e;

  function automatic int sum_width(
    input int positions,
    input int width
  );
    return width + $clog2(positions);
  endfunction

endpackage

// File: rtl/window_fill_ctrl.sv
// Fill counter and FILL/RUN control for the sliding window;
// flags the edge that completes the first full window.
module window_fill_ctrl
  import sliding_window_accumulator_pkg::*;
#(
  parameter int POSITIONS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_run,
  output logic o_fill_done,
  output logic o_valid
);

  localparam int CW = $clog2(POSITIONS + 1);
  localparam logic [CW-1:0] LAST = CW'(POSITIONS - 1);
  localparam logic [CW-1:0] FULL = CW'(POSITIONS);

  win_state_e r_state;
  win_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == RUN);
    end
  end

  // The clear-edge sample is window sample 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_fill_done = 1'b0;
    if (i_clear) begin
      w_state_nxt = FILL;
      w_cnt_nxt   = CW'(1);
    end else begin
      unique case (r_state)
        FILL: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt = RUN;
            o_fill_done = 1'b1;
          end
        end
        RUN: w_cnt_nxt = FULL;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  assign o_run   = (r_state == RUN);
  assign o_valid = r_valid;

endmodule

// File: rtl/sliding_window_accumulator.sv
// Running sum, average and peak over the last POSITIONS samples,
// fed by an external delay line that supplies the oldest sample.
module sliding_window_accumulator
  import sliding_window_accumulator_pkg::*;
#(
  parameter int POSITIONS = 8,
  parameter int WIDTH     = 8,
  localparam int SW = sum_width(POSITIONS, WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] si,
  input  logic [WIDTH-1:0] so,
  output logic [SW-1:0]    sum,
  output logic [WIDTH-1:0] avg,
  output logic             window_valid,
  output logic [SW-1:0]    peak
);

  logic          w_run;
  logic          w_fill_done;
  logic [SW-1:0] w_si;
  logic [SW-1:0] w_so;
  logic [SW-1:0] w_sum_nxt;
  logic [SW-1:0] w_peak_nxt;
  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_peak;

  window_fill_ctrl #(
    .POSITIONS(POSITIONS)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (clear),
    .o_run      (w_run),
    .o_fill_done(w_fill_done),
    .o_valid    (window_valid)
  );

  assign w_si = {{(SW-WIDTH){1'b0}}, si};
  assign w_so = {{(SW-WIDTH){1'b0}}, so};

  // so is stale until the window is full.
  always_comb begin
    w_sum_nxt  = r_sum + w_si;
    w_peak_nxt = r_peak;
    if (clear) begin
      w_sum_nxt  = w_si;
      w_peak_nxt = '0;
    end else if (w_run) begin
      w_sum_nxt = r_sum + w_si - w_so;
      if (w_sum_nxt > r_peak)
        w_peak_nxt = w_sum_nxt;
    end else if (w_fill_done) begin
      w_peak_nxt = w_sum_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_peak <= '0;
    end else begin
      r_sum  <= w_sum_nxt;
      r_peak <= w_peak_nxt;
    end
  end

  assign sum  = r_sum;
  assign peak = r_peak;
  assign avg  = r_sum[SW-1 -: WIDTH];

endmodule
